// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg
// Shared types and constants for the sqrt_arbiter block.
//   state_t     : FSM encoding {IDLE, LOAD, RUN, DONE}
//   VAL_W       : operand width handed to the sqrt core
//   ROOT_W      : root width returned by the sqrt core
//   DEF_TIMEOUT : default watchdog limit in RUN cycles
package sqrt_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int VAL_W       = 16;
  localparam int ROOT_W      = 8;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/rr_picker.sv
// rr_picker
// Combinational round-robin priority select. Grants the first set bit of
// valid at or after ptr, wrapping modulo N_REQ.
// Ports:
//   valid [N_REQ-1:0] in  : pending request vector
//   ptr   [ID_W-1:0]  in  : index with highest priority this cycle
//   grant [N_REQ-1:0] out : one-hot grant (all zero when nothing valid)
//   index [ID_W-1:0]  out : encoded grant index (0 when nothing valid)
//   any               out : at least one request is valid
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index,
  output logic             any
);

  int              pos;
  logic [ID_W-1:0] pos_idx;

  // Walk the vector starting at ptr; the first hit wins and later hits are
  // masked by 'any'.
  always_comb begin
    grant   = '0;
    index   = '0;
    any     = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_idx = pos[ID_W-1:0];
      if (!any && valid[pos_idx]) begin
        any            = 1'b1;
        grant[pos_idx] = 1'b1;
        index          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter
// Shares one sqrt core between N_REQ requesters. A round-robin pick in IDLE
// accepts one request, the operand is held on sq_valor while the core sits in
// reset for one LOAD cycle, the core then runs until endop, and the root is
// returned with the requester ID as a single-cycle strobe.
//
// Optional feature macro: SQRT_ARB_TIMEOUT_EN
//   defined   : watchdog aborts RUN after TIMEOUT cycles with rsp_err=1
//   undefined : RUN waits indefinitely, rsp_err tied to 0
//
// Ports:
//   clock, reset               : rising-edge clock, synchronous active-high reset
//   req_valid [N_REQ]          : request pending per requester
//   req_value [N_REQ*16]       : operands, requester i at [16i+15:16i]
//   req_ready [N_REQ]          : one-hot single-cycle accept
//   rsp_valid                  : single-cycle result strobe
//   rsp_id    [clog2(N_REQ)]   : ID of the requester answered (held)
//   rsp_sqrt  [8]              : floor square root (held)
//   rsp_err                    : watchdog timeout flag
//   sq_reset, sq_valor [16]    : drive the core's reset and operand
//   sq_endop, sq_sqrt [8]      : core completion flag and result
//   dbg_state                  : current FSM state for observation
//
// Handshake: a request transfers in the cycle where req_valid[i] and
// req_ready[i] are both high at the rising edge. req_ready is a one-cycle
// pulse; the requester must hold req_valid/req_value until it sees it and may
// drop or re-raise req_valid afterwards. rsp_valid is a one-cycle strobe with
// no back-pressure.
module sqrt_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*VAL_W-1:0]     req_value,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [ROOT_W-1:0]          rsp_sqrt,
  output logic                       rsp_err,
  output logic                       sq_reset,
  output logic [VAL_W-1:0]           sq_valor,
  input  logic                       sq_endop,
  input  logic [ROOT_W-1:0]          sq_sqrt,
  output state_t                     dbg_state
);

  localparam int ID_W = $clog2(N_REQ);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   cur_id;
  logic [ID_W-1:0]   next_ptr;
  logic              run_first;

  logic [N_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;

  logic [VAL_W-1:0]  val_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_split
    assign val_arr[i] = req_value[VAL_W*i +: VAL_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_idx),
    .any   (pick_any)
  );

  // The accept must be visible in the same IDLE cycle the pick is made, so
  // req_ready is decoded from the registered state rather than registered
  // itself. Masking with reset keeps it low while reset is held.
  assign req_ready = (state == IDLE && !reset) ? pick_grant : '0;

  assign next_ptr  = (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
  assign dbg_state = state;

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] run_cnt;
  logic             err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      run_first <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sqrt  <= '0;
      sq_reset  <= 1'b1;
      sq_valor  <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
      run_cnt   <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            sq_valor <= val_arr[pick_idx];
            cur_id   <= pick_idx;
            state    <= LOAD;
          end
        end
        // sq_reset stays high for this cycle so the core samples sq_valor.
        LOAD: begin
          sq_reset  <= 1'b0;
          run_first <= 1'b1;
`ifdef SQRT_ARB_TIMEOUT_EN
          run_cnt   <= '0;
`endif
          state     <= RUN;
        end
        // endop on the first RUN cycle can be left over from the previous
        // operation, so only later cycles are trusted.
        RUN: begin
          run_first <= 1'b0;
`ifdef SQRT_ARB_TIMEOUT_EN
          run_cnt   <= run_cnt + CNT_W'(1);
`endif
          if (!run_first && sq_endop) begin
            rsp_sqrt  <= sq_sqrt;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            sq_reset  <= 1'b1;
            state     <= DONE;
`ifdef SQRT_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
`ifdef SQRT_ARB_TIMEOUT_EN
          else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_sqrt  <= '0;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            sq_reset  <= 1'b1;
            state     <= DONE;
          end
`endif
        end
        DONE: begin
          rr_ptr <= next_ptr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter
// Self-checking bench for sqrt_arbiter with a behavioural sqrt core model,
// a round-robin reference model and a response scoreboard.
module tb_sqrt_arbiter;
  import sqrt_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*16-1:0] req_value = '0;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [1:0]      rsp_id;
  logic [7:0]      rsp_sqrt;
  logic            rsp_err;
  logic            sq_reset;
  logic [15:0]     sq_valor;
  logic            sq_endop = 1'b0;
  logic [7:0]      sq_sqrt  = 8'h00;
  state_t          dbg_state;

  sqrt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock     (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_value (req_value),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sqrt  (rsp_sqrt),
    .rsp_err   (rsp_err),
    .sq_reset  (sq_reset),
    .sq_valor  (sq_valor),
    .sq_endop  (sq_endop),
    .sq_sqrt   (sq_sqrt),
    .dbg_state (dbg_state)
  );

  // ---------------- reference math ----------------
  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  function automatic int model_pick(input logic [N-1:0] p, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (p[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // ---------------- behavioural sqrt core ----------------
  // Samples valor while held in reset, raises endop core_lat cycles after
  // release. force_stale leaves endop high (with a junk root) coming out of
  // reset; core_hang never finishes.
  logic [15:0] core_op = '0;
  int          core_cnt = 0;
  int          core_lat = 1;
  bit          core_hang = 1'b0;
  bit          force_stale = 1'b0;

  always @(posedge clk) begin
    if (sq_reset === 1'b1) begin
      core_cnt <= 0;
      core_op  <= sq_valor;
      sq_endop <= force_stale;
      sq_sqrt  <= force_stale ? 8'hAA : 8'h00;
    end else begin
      core_cnt <= core_cnt + 1;
      if (!core_hang && core_cnt + 1 >= core_lat) begin
        sq_endop <= 1'b1;
        sq_sqrt  <= isqrt(core_op);
      end else begin
        sq_endop <= 1'b0;
        sq_sqrt  <= 8'h55;
      end
    end
  end

  // ---------------- scoreboard / model state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  // {err, id[2:0], root[7:0], latency[7:0]}
  logic [19:0]   exp_q[$];
  int            got_ids[$];
  int            cyc = 0;
  int            acc_cyc = 0;
  int            mptr = 0;
  bit            busy = 1'b0;
  int            issue_left = 0;
  logic [N-1:0]  pend = '0;
  logic [N-1:0]  drop_mask = '0;
  logic [15:0]   mval [N];
  logic [N-1:0]  seed_mask = '0;
  logic [15:0]   seed_val [N];

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    core_hang = 1'b0;
    force_stale = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    busy = 1'b0;
    pend = '0;
    drop_mask = '0;
    exp_q.delete();
  endtask

  // Cycle-level driver + model + scoreboard. Seeds raise on the first cycle,
  // further random requests appear while issue_left > 0.
  task automatic run_sched(input int n_ops, input int budget, input int lat_lo,
                           input int lat_hi, input bit hang_first);
    int          done_ops = 0;
    int          cycles = 0;
    bit          first_acc = 1'b1;
    int          g;
    int          lat;
    logic [N-1:0] exp_ready;
    logic [19:0] e;
    logic [19:0] got;
    logic [15:0] v;
    while (done_ops < n_ops && cycles < budget) begin
      @(negedge clk);
      cycles++;
      cyc++;
      req_valid = req_valid & ~drop_mask;
      drop_mask = '0;
      for (int i = 0; i < N; i++) begin
        if (seed_mask[i]) begin
          pend[i] = 1'b1;
          mval[i] = seed_val[i];
          req_valid[i] = 1'b1;
          req_value[16*i +: 16] = seed_val[i];
        end else if (issue_left > 0 && !pend[i] && !req_valid[i] &&
                     $urandom_range(0, 3) == 0) begin
          issue_left--;
          case ($urandom_range(0, 7))
            0:       v = 16'd0;
            1:       v = 16'd65535;
            2:       v = 16'd65025;
            3:       v = 16'd65024;
            default: v = 16'($urandom_range(0, 65535));
          endcase
          pend[i] = 1'b1;
          mval[i] = v;
          req_valid[i] = 1'b1;
          req_value[16*i +: 16] = v;
        end
      end
      seed_mask = '0;
      #1;
      exp_ready = '0;
      g = -1;
      if (!busy) begin
        g = model_pick(pend, mptr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL req_ready cyc=%0d: got %b expected %b", cyc, req_ready, exp_ready);
      end
      if (g >= 0) begin
        busy = 1'b1;
        pend[g] = 1'b0;
        drop_mask[g] = 1'b1;
        acc_cyc = cyc;
        lat = $urandom_range(lat_lo, lat_hi);
        core_lat = lat;
        core_hang = hang_first && first_acc;
        first_acc = 1'b0;
        if (core_hang) e = {1'b1, 3'(g), 8'd0, 8'(TO + 2)};
        else           e = {1'b0, 3'(g), isqrt(mval[g]), 8'(lat + 3)};
        exp_q.push_back(e);
      end
      if (rsp_valid === 1'b1) begin
        got = {rsp_err, 1'b0, rsp_id, rsp_sqrt, 8'(cyc - acc_cyc)};
        got_ids.push_back(int'(rsp_id));
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got %h expected no response", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_fail++;
            $display("FAIL rsp {err,id,root,lat}: got %h expected %h", got, e);
          end
          mptr = (int'(e[18:16]) + 1) % N;
        end
        busy = 1'b0;
        done_ops++;
      end
    end
    n_checks++;
    if (done_ops < n_ops) begin
      n_fail++;
      $display("FAIL sched_budget: got %0d responses expected %0d", done_ops, n_ops);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [33:0] got;
    req_valid = '1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    got = {req_ready, rsp_valid, rsp_id, rsp_sqrt, rsp_err, sq_reset, sq_valor};
    n_checks++;
    if (got !== {4'b0, 1'b0, 2'b0, 8'b0, 1'b0, 1'b1, 16'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got %h expected %h", got,
               {4'b0, 1'b0, 2'b0, 8'b0, 1'b0, 1'b1, 16'b0});
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    core_lat = 1;
    req_valid = 4'b0001;
    req_value[15:0] = 16'd4;
    #1;
    n_checks++;
    if ({req_ready, sq_reset} !== {4'b0001, 1'b1}) begin
      n_fail++;
      $display("FAIL single_accept: got %b expected %b", {req_ready, sq_reset}, 5'b00011);
    end
    @(negedge clk);
    req_valid = '0;
    #1;
    n_checks++;
    if ({req_ready, sq_reset, sq_valor} !== {4'b0000, 1'b1, 16'd4}) begin
      n_fail++;
      $display("FAIL single_load: got %h expected %h", {req_ready, sq_reset, sq_valor},
               {4'b0000, 1'b1, 16'd4});
    end
    @(negedge clk);
    n_checks++;
    if (sq_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL single_run_reset: got %b expected 0", sq_reset);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_sqrt, rsp_err} !== {1'b1, 2'd0, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL single_rsp: got %h expected %h", {rsp_valid, rsp_id, rsp_sqrt, rsp_err},
               {1'b1, 2'd0, 8'd2, 1'b0});
    end
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_sqrt} !== {1'b0, 2'd0, 8'd2}) begin
      n_fail++;
      $display("FAIL single_hold: got %h expected %h", {rsp_valid, rsp_id, rsp_sqrt},
               {1'b0, 2'd0, 8'd2});
    end
    mptr = 1;
  endtask

  task automatic test_all_four();
    int exp_ord[4] = '{0, 1, 2, 3};
    do_reset();
    seed_mask = 4'b1111;
    seed_val[0] = 16'd16;
    seed_val[1] = 16'd81;
    seed_val[2] = 16'd65535;
    seed_val[3] = 16'd0;
    got_ids.delete();
    run_sched(4, 100, 1, 3, 1'b0);
    n_checks++;
    if (got_ids.size() != 4) begin
      n_fail++;
      $display("FAIL all4_count: got %0d expected 4", got_ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_ids[i] != exp_ord[i]) begin
          n_fail++;
          $display("FAIL all4_order[%0d]: got %0d expected %0d", i, got_ids[i], exp_ord[i]);
        end
      end
    end
  endtask

  task automatic test_rr_ptr();
    seed_mask = 4'b0010;
    seed_val[1] = 16'd49;
    run_sched(1, 50, 1, 2, 1'b0);
    seed_mask = 4'b1010;
    seed_val[1] = 16'd100;
    seed_val[3] = 16'd900;
    got_ids.delete();
    run_sched(2, 80, 1, 4, 1'b0);
    n_checks++;
    if (got_ids.size() != 2 || got_ids[0] != 3 || got_ids[1] != 1) begin
      n_fail++;
      $display("FAIL rr_order: got %p expected '{3, 1}", got_ids);
    end
  endtask

  task automatic test_stale_endop();
    force_stale = 1'b1;
    seed_mask = 4'b0100;
    seed_val[2] = 16'd225;
    run_sched(1, 50, 2, 2, 1'b0);
    seed_mask = 4'b0001;
    seed_val[0] = 16'd1;
    run_sched(1, 50, 1, 1, 1'b0);
    force_stale = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    bit saw = 1'b0;
    logic [33:0] got;
    @(negedge clk);
    core_lat = 6;
    req_valid = 4'b0001;
    req_value[15:0] = 16'd144;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_accept: got %b expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    got = {req_ready, rsp_valid, rsp_id, rsp_sqrt, rsp_err, sq_reset, sq_valor};
    n_checks++;
    if (got !== {4'b0, 1'b0, 2'b0, 8'b0, 1'b0, 1'b1, 16'b0}) begin
      n_fail++;
      $display("FAIL mid_reset_values: got %h expected %h", got,
               {4'b0, 1'b0, 2'b0, 8'b0, 1'b0, 1'b1, 16'b0});
    end
    rst = 1'b0;
    mptr = 0;
    busy = 1'b0;
    pend = '0;
    drop_mask = '0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw) begin
      n_fail++;
      $display("FAIL mid_no_rsp: got rsp_valid=1 expected 0");
    end
    seed_mask = 4'b0001;
    seed_val[0] = 16'd144;
    run_sched(1, 50, 1, 3, 1'b0);
  endtask

  task automatic test_random();
    issue_left = 40;
    run_sched(40, 3000, 1, 5, 1'b0);
  endtask

`ifdef SQRT_ARB_TIMEOUT_EN
  task automatic test_timeout();
    seed_mask = 4'b0010;
    seed_val[1] = 16'd400;
    run_sched(1, 100, 1, 1, 1'b1);
    seed_mask = 4'b0010;
    seed_val[1] = 16'd400;
    run_sched(1, 100, 1, 3, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_ptr();
    test_stale_endop();
    test_reset_mid_run();
    test_random();
`ifdef SQRT_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
